// File: rtl/echo_request_deframer.sv
// Header-validating deframer: turns host word frames into 96-bit EchoRequest messages behind a small FIFO.
// Optional drop counter port enabled by defining ECHO_DEFRAMER_DROP_COUNT_EN.
module echo_request_deframer #(
    parameter int          DEPTH   = 2,
    parameter logic [15:0] SAY_TAG = 16'd1,
    parameter logic [15:0] SAY_LEN = 16'd2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        beat__ENA,
    input  logic [31:0] beat_v,
    output logic        beat__RDY,
    output logic        pipe_enq__ENA,
    output logic [95:0] pipe_enq_v,
    input  logic        pipe_enq__RDY
`ifdef ECHO_DEFRAMER_DROP_COUNT_EN
    ,
    output logic [15:0] drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_PAY   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        idx_r;
    logic [15:0] remaining_r;
    logic [15:0] tag_r;
    logic [31:0] meth_r;
    logic [95:0] mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;

    logic        full_s;
    logic        empty_s;
    logic        beat_rdy_s;
    logic        word_acc_s;
    logic        push_s;
    logic        pop_s;
    logic        say_hdr_s;
    logic [15:0] hdr_len_s;
    logic [15:0] hdr_tag_s;

    assign hdr_len_s = beat_v[31:16];
    assign hdr_tag_s = beat_v[15:0];
    assign say_hdr_s = (hdr_tag_s == SAY_TAG) && (hdr_len_s == SAY_LEN);

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // Only the final payload word can be refused; everything else is always absorbed.
    assign beat_rdy_s = !((state_r == ST_PAY) && idx_r && full_s);
    assign word_acc_s = beat__ENA && beat_rdy_s;
    assign pop_s      = !empty_s && pipe_enq__RDY;

    assign beat__RDY     = beat_rdy_s;
    assign pipe_enq__ENA = !empty_s;
    assign pipe_enq_v    = mem_r[rd_ptr_r[AW-1:0]];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_HDR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_HDR: begin
                if (word_acc_s) begin
                    if (say_hdr_s) begin
                        state_next_s = ST_PAY;
                    end else if (hdr_len_s == 16'd0) begin
                        state_next_s = ST_HDR;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_PAY: begin
                if (word_acc_s && idx_r) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_PAY;
                end
            end
            ST_DRAIN: begin
                if (word_acc_s && (remaining_r == 16'd1)) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_HDR;
        endcase
    end

    // FSM outputs: FIFO push on the last payload word.
    always_comb begin
        push_s = 1'b0;
        case (state_r)
            ST_PAY:  push_s = word_acc_s && idx_r;
            default: push_s = 1'b0;
        endcase
    end

    // Frame datapath: header fields, payload index and drain countdown.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_r       <= 1'b0;
            remaining_r <= 16'd0;
            tag_r       <= 16'd0;
            meth_r      <= 32'd0;
        end else if (word_acc_s && (state_r == ST_HDR)) begin
            tag_r       <= hdr_tag_s;
            remaining_r <= hdr_len_s;
            idx_r       <= 1'b0;
        end else if (word_acc_s && (state_r == ST_PAY) && !idx_r) begin
            meth_r <= beat_v;
            idx_r  <= 1'b1;
        end else if (word_acc_s && (state_r == ST_PAY)) begin
            idx_r <= 1'b0;
        end else if (word_acc_s && (state_r == ST_DRAIN)) begin
            remaining_r <= remaining_r - 16'd1;
        end else begin
            idx_r       <= idx_r;
            remaining_r <= remaining_r;
        end
    end

    // Output FIFO storage and pointers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 96'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {beat_v, meth_r, 16'd0, tag_r};
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

`ifdef ECHO_DEFRAMER_DROP_COUNT_EN
    logic        drop_done_s;
    logic [15:0] drop_count_r;

    // A drop completes on a zero-length header or on the last drained word.
    always_comb begin
        drop_done_s = 1'b0;
        case (state_r)
            ST_HDR:   drop_done_s = word_acc_s && !say_hdr_s && (hdr_len_s == 16'd0);
            ST_DRAIN: drop_done_s = word_acc_s && (remaining_r == 16'd1);
            default:  drop_done_s = 1'b0;
        endcase
    end

    // Saturating dropped-frame counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_count_r <= 16'd0;
        end else if (drop_done_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign drop_count = drop_count_r;
`endif

endmodule

// File: tb/tb_echo_request_deframer.sv
// Randomised bench for echo_request_deframer with a frame-level reference model and scoreboard.
module tb_echo_request_deframer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        beat__ENA;
    logic [31:0] beat_v;
    logic        beat__RDY;
    logic        pipe_enq__ENA;
    logic [95:0] pipe_enq_v;
    logic        pipe_enq__RDY;
`ifdef ECHO_DEFRAMER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int          checks      = 0;
    int          failures    = 0;
    int          rdy_mode    = 2;
    int          model_drops = 0;
    bit          gaps_en     = 1'b0;
    logic [95:0] exp_q[$];
    logic [31:0] frame_q[$];

    echo_request_deframer #(.DEPTH(2)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .beat__ENA     (beat__ENA),
        .beat_v        (beat_v),
        .beat__RDY     (beat__RDY),
        .pipe_enq__ENA (pipe_enq__ENA),
        .pipe_enq_v    (pipe_enq_v),
        .pipe_enq__RDY (pipe_enq__RDY)
`ifdef ECHO_DEFRAMER_DROP_COUNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Downstream ready: 0 = random, 1 = held low, otherwise held high.
    initial begin
        pipe_enq__RDY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       pipe_enq__RDY = 1'($urandom_range(0, 1));
                1:       pipe_enq__RDY = 1'b0;
                default: pipe_enq__RDY = 1'b1;
            endcase
        end
    end

    // Scoreboard: every accepted message must match the oldest expected one.
    initial begin
        logic [95:0] e;
        forever begin
            @(negedge CLK);
            if (!RST && pipe_enq__ENA && pipe_enq__RDY) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_msg", pipe_enq_v, 96'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("msg", pipe_enq_v, e);
                end
            end
        end
    end

    // Reference rule: only tag 1 with exactly two payload words forms a message.
    task automatic model_frame();
        logic [15:0] len;
        logic [15:0] tag;
        len = frame_q[0][31:16];
        tag = frame_q[0][15:0];
        if (tag == 16'd1 && len == 16'd2) begin
            exp_q.push_back({frame_q[2], frame_q[1], 16'd0, tag});
        end else begin
            model_drops++;
        end
    endtask

    task automatic make_frame(input logic [15:0] len, input logic [15:0] tag);
        frame_q.delete();
        frame_q.push_back({len, tag});
        for (int i = 0; i < int'(len); i++) begin
            frame_q.push_back($urandom);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        beat__ENA = 1'b1;
        beat_v    = w;
        @(negedge CLK);
        while (!beat__RDY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!beat__RDY) begin
            check_val("beat_rdy_timeout", 96'(beat__RDY), 96'd1);
        end
        @(posedge CLK);
        #1;
        beat__ENA = 1'b0;
        if (gaps_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic send_frame();
        model_frame();
        while (frame_q.size() > 0) begin
            send_word(frame_q.pop_front());
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        rdy_mode = 2;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge CLK);
            n++;
        end
        repeat (2) @(posedge CLK);
        #1;
        check_val("drain_empty", 96'(exp_q.size()), 96'd0);
    endtask

    task automatic check_drops();
`ifdef ECHO_DEFRAMER_DROP_COUNT_EN
        logic [15:0] e;
        e = (model_drops > 65535) ? 16'hFFFF : 16'(model_drops);
        check_val("drop_count", 96'(drop_count), 96'(e));
`endif
    endtask

    initial begin
        logic [15:0] len;
        logic [15:0] tag;
        RST       = 1'b1;
        beat__ENA = 1'b0;
        beat_v    = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_beat_rdy", 96'(beat__RDY), 96'd1);
        check_val("rst_enq_ena", 96'(pipe_enq__ENA), 96'd0);
        check_val("rst_enq_v", pipe_enq_v, 96'd0);
        RST = 1'b0;
        check_drops();

        // Basic say frame and first-message latency.
        frame_q = '{32'h0002_0001, 32'h0000_0007, 32'h0000_00AA};
        model_frame();
        send_word(frame_q[0]);
        send_word(frame_q[1]);
        check_val("lat_before", 96'(pipe_enq__ENA), 96'd0);
        send_word(frame_q[2]);
        check_val("lat_ena", 96'(pipe_enq__ENA), 96'd1);
        check_val("lat_data", pipe_enq_v, {32'h0000_00AA, 32'h0000_0007, 32'h0000_0001});
        wait_drain();
        check_drops();

        // Mismatched frame is drained, then a valid one.
        frame_q = '{32'h0003_0005, 32'd1, 32'd2, 32'd3};
        send_frame();
        make_frame(16'd2, 16'd1);
        send_frame();
        wait_drain();
        check_drops();

        // Zero-length header, then a valid one.
        frame_q = '{32'h0000_0001};
        send_frame();
        make_frame(16'd2, 16'd1);
        send_frame();
        wait_drain();
        check_drops();

        // Backpressure: two frames fill the FIFO, third stalls on its last word.
        rdy_mode = 1;
        repeat (2) begin
            make_frame(16'd2, 16'd1);
            send_frame();
        end
        make_frame(16'd2, 16'd1);
        model_frame();
        send_word(frame_q[0]);
        send_word(frame_q[1]);
        beat__ENA = 1'b1;
        beat_v    = frame_q[2];
        @(negedge CLK);
        check_val("full_stall", 96'(beat__RDY), 96'd0);
        check_val("full_ena", 96'(pipe_enq__ENA), 96'd1);
        repeat (2) @(negedge CLK);
        check_val("full_stall_hold", 96'(beat__RDY), 96'd0);
        rdy_mode = 2;
        send_word(frame_q[2]);
        wait_drain();

        // Reset mid-frame discards header and meth.
        send_word(32'h0002_0001);
        send_word(32'h0000_0005);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST         = 1'b0;
        model_drops = 0;
        check_val("mid_rst_ena", 96'(pipe_enq__ENA), 96'd0);
        frame_q = '{32'h0002_0001, 32'h1122_3344, 32'h5566_7788};
        send_frame();
        wait_drain();
        check_drops();

        // Random mix of good, zero-length and drained frames.
        gaps_en  = 1'b1;
        rdy_mode = 0;
        repeat (40) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    len = 16'd2;
                    tag = 16'd1;
                end
                2: begin
                    len = 16'd0;
                    tag = 16'($urandom_range(0, 3));
                end
                default: begin
                    len = 16'($urandom_range(1, 4));
                    tag = 16'($urandom_range(0, 3));
                    if (tag == 16'd1 && len == 16'd2) begin
                        len = 16'd3;
                    end
                end
            endcase
            make_frame(len, tag);
            send_frame();
        end
        wait_drain();
        check_drops();
        gaps_en = 1'b0;

`ifdef ECHO_DEFRAMER_DROP_COUNT_EN
        // Saturation of the drop counter.
        repeat (65537) begin
            send_word(32'h0000_0009);
        end
        model_drops += 65537;
        check_drops();
        check_val("sat_no_msg", 96'(pipe_enq__ENA), 96'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
